// File: rtl/cntr_ctrl_pkg.sv
// Shared types and constants for the cntr_ctrl counter controller.
package cntr_ctrl_pkg;

   // Default counter width in bits. The legal range is 2..16.
   localparam int DEFAULT_WIDTH = 4;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : cntr_ctrl_pkg

// File: rtl/cntr_core.sv
// WIDTH-bit synchronous up-counter with clear, enable and terminal-count compare.
// At terminal count an enabled step either wraps to 0 (i_wrap=1) or holds.
module cntr_core
   import cntr_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_wrap,
   input  logic [WIDTH-1:0] i_tc,
   output logic [WIDTH-1:0] o_count,
   output logic             o_at_tc
);

   logic [WIDTH-1:0] r_count;
   logic             w_at_tc;

   assign w_at_tc = (r_count == i_tc);

   // Counter register: clear wins over enable; step, wrap or hold at terminal count.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is just the highest-priority branch inside the clocked block.
      if (!rstn) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         if (w_at_tc) begin
            if (i_wrap) r_count <= '0;
         end else begin
            r_count <= r_count + WIDTH'(1);
         end
      end
   end

   assign o_count = r_count;
   assign o_at_tc = w_at_tc;

endmodule : cntr_core

// File: rtl/cntr_ctrl.sv
// Counter controller: IDLE/RUN/HOLD/DONE FSM around a cntr_core up-counter.
// Input priority is stop > start > hold. done is a registered one-cycle pulse.
// Optional feature: define CNTR_CTRL_PRESCALE_EN to add the 4-bit prescaler
// and the presc port; otherwise the counter steps every cycle.
module cntr_ctrl
   import cntr_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] tc_val,
`ifdef CNTR_CTRL_PRESCALE_EN
   input  logic [3:0]       presc,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_tc_lat;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_clr;
   logic             w_latch;
   logic             w_step;    // a live counting cycle: RUN/HOLD with hold released
   logic             w_tick;
   logic             w_en;
   logic             w_at_tc;

   // State register, terminal-count latch and done pulse register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_tc_lat <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         if (w_latch) r_tc_lat <= tc_val;
      end
   end

   // Next-state and counter control decode, stop > start > hold.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_latch     = 1'b0;
      w_step      = 1'b0;
      w_done_nxt  = 1'b0;
      if (stop) begin
         w_state_nxt = ST_IDLE;
         w_clr       = 1'b1;
      end else if (start) begin
         w_state_nxt = ST_RUN;
         w_clr       = 1'b1;
         w_latch     = 1'b1;
      end else begin
         case (r_state)
            ST_RUN, ST_HOLD: begin
               // A cycle with hold=1 is frozen; a cycle with hold=0 counts, including
               // the one leaving HOLD, so a hold of N cycles delays the sequence by N.
               if (hold) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_step      = 1'b1;
                  if (w_tick && w_at_tc) begin
                     w_done_nxt = 1'b1;
                     // auto_reload is sampled live at the terminal tick.
                     if (!auto_reload) w_state_nxt = ST_DONE;
                  end
               end
            end
            default: begin
               // IDLE and DONE wait for start or stop.
            end
         endcase
      end
   end

   assign w_en = w_step & w_tick;

`ifdef CNTR_CTRL_PRESCALE_EN
   logic [3:0] r_psc;

   assign w_tick = (r_psc == presc);

   // Prescaler: cleared on start, frozen outside counting cycles, wraps after a tick.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_psc <= 4'd0;
      end else if (!stop && start) begin
         r_psc <= 4'd0;
      end else if (w_step) begin
         r_psc <= w_tick ? 4'd0 : r_psc + 4'd1;
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   cntr_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_wrap  (auto_reload),
      .i_tc    (r_tc_lat),
      .o_count (count),
      .o_at_tc (w_at_tc)
   );

   assign busy = (r_state == ST_RUN) || (r_state == ST_HOLD);
   assign done = r_done;

endmodule : cntr_ctrl

// File: tb/tb_cntr_ctrl.sv
// Self-checking bench for cntr_ctrl: directed sequences followed by random
// stimulus, compared every cycle against a behavioural model of the counter.
// Define CNTR_CTRL_PRESCALE_EN to exercise the prescaled build.
module tb_cntr_ctrl;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic             stop;
   logic             hold;
   logic             auto_reload;
   logic [WIDTH-1:0] tc_val;
`ifdef CNTR_CTRL_PRESCALE_EN
   logic [3:0]       presc;
`endif
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: "running" flag, integer count, latched terminal value.
   bit m_running;
   bit m_done;
   int m_count;
   int m_tc;
   int m_psc;

   cntr_ctrl #(
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .stop        (stop),
      .hold        (hold),
      .auto_reload (auto_reload),
      .tc_val      (tc_val),
`ifdef CNTR_CTRL_PRESCALE_EN
      .presc       (presc),
`endif
      .count       (count),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Apply the current inputs for one rising edge, advancing the model by the same rules.
   task automatic step(input string tag);
      bit tick;
      m_done = 1'b0;
      if (!rstn) begin
         m_running = 1'b0;
         m_count   = 0;
         m_tc      = 0;
         m_psc     = 0;
      end else if (stop) begin
         m_running = 1'b0;
         m_count   = 0;
      end else if (start) begin
         m_running = 1'b1;
         m_count   = 0;
         m_tc      = int'(tc_val);
         m_psc     = 0;
      end else if (m_running && !hold) begin
`ifdef CNTR_CTRL_PRESCALE_EN
         tick  = (m_psc == int'(presc));
         m_psc = tick ? 0 : (m_psc + 1) % 16;
`else
         tick = 1'b1;
`endif
         if (tick) begin
            if (m_count != m_tc) begin
               m_count = m_count + 1;
            end else begin
               m_done = 1'b1;
               if (auto_reload) m_count = 0;
               else             m_running = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      check({tag, ".count"}, 32'(count), 32'(m_count));
      check({tag, ".busy"},  32'(busy),  32'(m_running));
      check({tag, ".done"},  32'(done),  32'(m_done));
   endtask

   task automatic idle_inputs();
      start = 1'b0;
      stop  = 1'b0;
      hold  = 1'b0;
   endtask

   initial begin
      rstn        = 1'b0;
      auto_reload = 1'b0;
      tc_val      = '0;
`ifdef CNTR_CTRL_PRESCALE_EN
      presc       = 4'd0;
`endif
      idle_inputs();
      m_running = 1'b0;
      m_done    = 1'b0;
      m_count   = 0;
      m_tc      = 0;
      m_psc     = 0;

      // Reset state.
      step("reset0");
      step("reset1");
      rstn = 1'b1;

      // One-shot, tc=3: 0,1,2,3 then done pulse, then DONE with count=3.
      tc_val = 4'd3;
      start  = 1'b1;
      step("oneshot_start");
      start  = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tc_val = WIDTH'($urandom());  // ignored while busy
         step("oneshot");
      end

      // Auto-reload, tc=2: 0,1,2,0,1,2 with done every 3rd cycle.
      tc_val      = 4'd2;
      auto_reload = 1'b1;
      start       = 1'b1;
      step("reload_start");
      start = 1'b0;
      for (int i = 0; i < 10; i++) step("reload");

      // Hold for 5 cycles at count=1, tc=4.
      tc_val      = 4'd4;
      auto_reload = 1'b0;
      start       = 1'b1;
      step("hold_start");
      start = 1'b0;
      step("hold_pre");
      hold = 1'b1;
      for (int i = 0; i < 5; i++) step("hold_frozen");
      hold = 1'b0;
      for (int i = 0; i < 6; i++) step("hold_resume");

      // stop and start together at count=2: stop wins.
      tc_val = 4'd5;
      start  = 1'b1;
      step("ss_start");
      start = 1'b0;
      step("ss_run");
      step("ss_run");
      stop  = 1'b1;
      start = 1'b1;
      step("ss_both");
      idle_inputs();
      step("ss_idle");

      // Restart mid-run with a new terminal value.
      tc_val = 4'd3;
      start  = 1'b1;
      step("rs_start");
      start = 1'b0;
      step("rs_run");
      step("rs_run");
      tc_val = 4'd6;
      start  = 1'b1;
      step("rs_restart");
      start = 1'b0;
      for (int i = 0; i < 8; i++) step("rs_run2");

      // Reset at count=3 overrides a simultaneous start.
      tc_val = 4'd7;
      start  = 1'b1;
      step("rst_start");
      start = 1'b0;
      for (int i = 0; i < 3; i++) step("rst_run");
      rstn  = 1'b0;
      start = 1'b1;
      hold  = 1'b1;
      step("rst_mid");
      rstn = 1'b1;
      idle_inputs();
      step("rst_after");

      // tc=0: done every cycle with auto-reload, then one-shot once reload drops.
      tc_val      = 4'd0;
      auto_reload = 1'b1;
      start       = 1'b1;
      step("tc0_start");
      start = 1'b0;
      for (int i = 0; i < 4; i++) step("tc0_reload");
      auto_reload = 1'b0;
      for (int i = 0; i < 3; i++) step("tc0_oneshot");

`ifdef CNTR_CTRL_PRESCALE_EN
      // presc=2, tc=1: a step every 3 cycles, done 6 cycles after count=0.
      presc  = 4'd2;
      tc_val = 4'd1;
      start  = 1'b1;
      step("psc_start");
      start = 1'b0;
      for (int i = 0; i < 9; i++) step("psc_run");
`endif

      // Random stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         rstn  = ($urandom_range(63) != 0);
         stop  = ($urandom_range(15) == 0);
         start = ($urandom_range(9) == 0);
         hold  = ($urandom_range(3) == 0);
         if ($urandom_range(7) == 0) auto_reload = 1'($urandom_range(1));
         tc_val = WIDTH'($urandom());
`ifdef CNTR_CTRL_PRESCALE_EN
         if ($urandom_range(15) == 0) presc = 4'($urandom_range(3));
`endif
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_cntr_ctrl
